// File: rtl/text_ram_pkg.sv
// Shared sizes and FSM state type for the text-mode character RAM arbiter.
package text_ram_pkg;
   localparam int TEXT_COLS = 64;
   localparam int TEXT_ROWS = 24;
   localparam int NUM_WORDS = 1536;
   localparam int ADDR_W    = 11;
   localparam int DATA_W    = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      ACK     = 2'd2,
      CLEAR   = 2'd3
   } arb_state_t;

   function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
      return a < ADDR_W'(NUM_WORDS);
   endfunction
endpackage

// File: rtl/text_clear_counter.sv
// Clear-screen address counter: restarts on i_start, advances on each clear write,
// flags the write to the last word so the arbiter can leave CLEAR.
module text_clear_counter
   import text_ram_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_wr_en,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_last
);
   logic [ADDR_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_start) begin
         r_count <= '0;
      end else if (i_wr_en) begin
         r_count <= o_last ? '0 : r_count + 1'b1;
      end
   end

   assign o_addr = r_count;
   assign o_last = i_wr_en && (r_count == ADDR_W'(NUM_WORDS - 1));
endmodule

// File: rtl/text_ram_arbiter.sv
// Shares one single-port text RAM between display fetch, CPU access and screen clear.
// Display always wins the port; CPU waits in IDLE, clear stalls its counter.
module text_ram_arbiter
   import text_ram_pkg::*;
(
   input  logic              CLOCK_50,
   input  logic              RESET,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_char,
   output logic              clr_busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_q
);
   arb_state_t        r_state;
   arb_state_t        w_next;
   logic              r_disp_p1;
   logic              r_disp_oor;
   logic              r_disp_valid;
   logic [DATA_W-1:0] r_disp_data;
   logic              r_cpu_oor;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_clr_char;
   logic              w_clr_start;
   logic              w_cpu_grant;
   logic              w_clr_wr;
   logic              w_clr_last;
   logic [ADDR_W-1:0] w_clr_addr;

   assign w_clr_start = (r_state == IDLE) && clr_start;
   assign w_cpu_grant = (r_state == IDLE) && cpu_req && !clr_start && !disp_req;
   assign w_clr_wr    = (r_state == CLEAR) && !disp_req;

   text_clear_counter u_clr_cnt (
      .i_clk   (CLOCK_50),
      .i_rst   (RESET),
      .i_start (w_clr_start),
      .i_wr_en (w_clr_wr),
      .o_addr  (w_clr_addr),
      .o_last  (w_clr_last)
   );

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (clr_start) begin
               w_next = CLEAR;
            end else if (w_cpu_grant) begin
               if (cpu_we) w_next = ACK;
               else        w_next = RD_WAIT;
            end
         end
         RD_WAIT: w_next = ACK;
         ACK:     w_next = IDLE;
         CLEAR:   if (w_clr_last) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      ram_addr  = disp_addr;
      ram_wdata = '0;
      ram_wren  = 1'b0;
      if (disp_req) begin
         ram_addr = disp_addr;
      end else if (w_cpu_grant) begin
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
         ram_wren  = cpu_we && addr_in_range(cpu_addr);
      end else if (w_clr_wr) begin
         ram_addr  = w_clr_addr;
         ram_wdata = r_clr_char;
         ram_wren  = 1'b1;
      end
      // The RAM is not reset, so a write in a reset cycle would survive it.
      if (RESET) ram_wren = 1'b0;
      cpu_ack  = (r_state == ACK);
      clr_busy = (r_state == CLEAR);
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_disp_p1    <= 1'b0;
         r_disp_oor   <= 1'b0;
         r_disp_valid <= 1'b0;
         r_disp_data  <= '0;
         r_cpu_oor    <= 1'b0;
         r_cpu_rdata  <= '0;
         r_clr_char   <= '0;
      end else begin
         r_disp_p1    <= disp_req;
         r_disp_oor   <= !addr_in_range(disp_addr);
         r_disp_valid <= r_disp_p1;
         if (r_disp_p1) r_disp_data <= r_disp_oor ? '0 : ram_q;
         if (w_cpu_grant) r_cpu_oor <= !addr_in_range(cpu_addr);
         if (r_state == RD_WAIT) r_cpu_rdata <= r_cpu_oor ? '0 : ram_q;
         if (w_clr_start) r_clr_char <= clr_char;
      end
   end

   assign disp_valid = r_disp_valid;
   assign disp_data  = r_disp_data;
   assign cpu_rdata  = r_cpu_rdata;
endmodule

// File: tb/tb_text_ram_arbiter.sv
// Bench for text_ram_arbiter: behavioural RAM plus an expected-contents model of the text buffer.
`timescale 1ns/1ps
module tb_text_ram_arbiter;
   localparam int NW = 1536;

   logic        CLOCK_50 = 1'b0;
   logic        RESET;
   logic        disp_req;
   logic [10:0] disp_addr;
   logic [7:0]  disp_data;
   logic        disp_valid;
   logic        cpu_req;
   logic        cpu_we;
   logic [10:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        clr_start;
   logic [7:0]  clr_char;
   logic        clr_busy;
   logic [10:0] ram_addr;
   logic        ram_wren;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_q;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int         due;
      logic [7:0] d;
   } disp_exp_t;

   logic [7:0] ref_mem [0:NW-1];

   text_ram_arbiter dut (
      .CLOCK_50(CLOCK_50), .RESET(RESET),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .clr_start(clr_start), .clr_char(clr_char), .clr_busy(clr_busy),
      .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata), .ram_q(ram_q)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Single-port RAM: registered address, unregistered output; out-of-range reads return junk.
   logic [7:0]  ram [0:NW-1];
   logic [10:0] ram_raddr;
   logic        preload = 1'b0;
   always @(posedge CLOCK_50) begin
      if (preload) begin
         for (int i = 0; i < NW; i++) ram[i] <= 8'(i);
      end else if (ram_wren && ram_addr < 11'd1536) begin
         ram[ram_addr] <= ram_wdata;
      end
      ram_raddr <= ram_addr;
   end
   assign ram_q = (ram_raddr < 11'd1536) ? ram[ram_raddr] : 8'hEE;

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic sample();
      @(negedge CLOCK_50);
   endtask

   task automatic set_idle();
      disp_req = 0; disp_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0;
      cpu_wdata = '0; clr_start = 0; clr_char = '0;
   endtask

   task automatic test_reset();
      set_idle();
      RESET = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 11'd5; cpu_wdata = 8'hAA;
      tick();
      sample();
      checks++;
      if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", ram_wren); end
      tick();
      set_idle(); RESET = 0;
      sample();
      checks++;
      if ({cpu_ack, cpu_rdata, disp_valid, disp_data, clr_busy, ram_wren} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs: ack=%b rdata=%h dv=%b dd=%h busy=%b wren=%b expected all 0",
                  cpu_ack, cpu_rdata, disp_valid, disp_data, clr_busy, ram_wren);
      end
      tick();
   endtask

   task automatic test_display_only();
      preload = 1; tick(); preload = 0;
      for (int i = 0; i < NW; i++) ref_mem[i] = 8'(i);
      for (int i = 0; i < 66; i++) begin
         disp_req = (i < 64); disp_addr = 11'((i < 64) ? i : 0);
         sample();
         checks++;
         if (disp_valid !== (i >= 2)) begin
            errors++; $display("FAIL disp_only_valid[%0d]: got %b expected %b", i, disp_valid, (i >= 2));
         end
         if (i >= 2) begin
            checks++;
            if (disp_data !== 8'(i - 2)) begin
               errors++; $display("FAIL disp_only_data[%0d]: got %h expected %h", i, disp_data, 8'(i - 2));
            end
         end
         tick();
      end
      disp_req = 0;
   endtask

   task automatic test_cpu_write_read();
      cpu_req = 1; cpu_we = 1; cpu_addr = 11'd130; cpu_wdata = 8'h41;
      sample();
      checks++;
      if (ram_wren !== 1'b1 || ram_addr !== 11'd130 || ram_wdata !== 8'h41 || cpu_ack !== 1'b0) begin
         errors++; $display("FAIL cpu_wr_grant: wren=%b addr=%0d data=%h ack=%b expected 1/130/41/0",
                            ram_wren, ram_addr, ram_wdata, cpu_ack);
      end
      tick();
      sample();
      checks++;
      if (cpu_ack !== 1'b1 || ram_wren !== 1'b0) begin
         errors++; $display("FAIL cpu_wr_ack: ack=%b wren=%b expected 1/0", cpu_ack, ram_wren);
      end
      tick();
      cpu_req = 0; ref_mem[130] = 8'h41;
      sample();
      checks++;
      if (cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_wr_ack_len: got %b expected 0", cpu_ack); end
      tick();
      cpu_req = 1; cpu_we = 0;
      for (int c = 0; c < 3; c++) begin
         sample();
         checks++;
         if (cpu_ack !== (c == 2) || ram_wren !== 1'b0) begin
            errors++; $display("FAIL cpu_rd_ack[%0d]: ack=%b wren=%b expected %b/0", c, cpu_ack, ram_wren, (c == 2));
         end
         if (c == 0) begin
            checks++;
            if (ram_addr !== 11'd130) begin errors++; $display("FAIL cpu_rd_addr: got %0d expected 130", ram_addr); end
         end
         if (c == 2) begin
            checks++;
            if (cpu_rdata !== 8'h41) begin errors++; $display("FAIL cpu_rd_data: got %h expected 41", cpu_rdata); end
         end
         tick();
      end
      cpu_req = 0;
   endtask

   task automatic test_display_priority();
      logic [7:0] dq[$];
      cpu_req = 1; cpu_we = 0; cpu_addr = 11'd130;
      for (int c = 0; c < 8; c++) begin
         disp_req = (c < 5);
         disp_addr = 11'($urandom_range(0, NW - 1));
         if (disp_req) dq.push_back(ref_mem[disp_addr]);
         sample();
         checks++;
         if (c < 5 && (ram_addr !== disp_addr || ram_wren !== 1'b0)) begin
            errors++; $display("FAIL prio_disp_owns[%0d]: addr=%0d wren=%b expected %0d/0", c, ram_addr, ram_wren, disp_addr);
         end else if (c == 5 && ram_addr !== 11'd130) begin
            errors++; $display("FAIL prio_cpu_grant: addr=%0d expected 130", ram_addr);
         end
         checks++;
         if (cpu_ack !== (c == 7)) begin
            errors++; $display("FAIL prio_ack[%0d]: got %b expected %b", c, cpu_ack, (c == 7));
         end else if (c == 7 && cpu_rdata !== 8'h41) begin
            errors++; $display("FAIL prio_rdata: got %h expected 41", cpu_rdata);
         end
         checks++;
         if (disp_valid !== (c >= 2 && c <= 6)) begin
            errors++; $display("FAIL prio_disp_valid[%0d]: got %b expected %b", c, disp_valid, (c >= 2 && c <= 6));
         end else if (disp_valid === 1'b1) begin
            if (disp_data !== dq[0]) begin
               errors++; $display("FAIL prio_disp_data[%0d]: got %h expected %h", c, disp_data, dq[0]);
            end
            void'(dq.pop_front());
         end
         tick();
      end
      cpu_req = 0; disp_req = 0;
   endtask

   task automatic test_random_mix();
      disp_exp_t   dq[$];
      bit          act = 0, gnt = 0, we = 0, exp_wren, exp_v, exp_ack;
      int          due = 0;
      logic [10:0] a = '0;
      logic [7:0]  wd = '0, exp_rd = '0;
      for (int c = 0; c < 600; c++) begin
         disp_req  = (c < 580) && ($urandom_range(0, 1) == 1);
         disp_addr = 11'($urandom_range(0, 1700));
         if (!act && c < 580 && $urandom_range(0, 2) == 0) begin
            act = 1; gnt = 0; we = ($urandom_range(0, 1) == 1);
            a = 11'($urandom_range(0, 1599)); wd = 8'($urandom);
         end
         cpu_req = act; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
         exp_wren = 0;
         if (disp_req) begin
            dq.push_back('{c + 2, (disp_addr < 11'd1536) ? ref_mem[disp_addr] : 8'h00});
         end else if (act && !gnt) begin
            gnt = 1; due = c + (we ? 1 : 2);
            if (we) begin
               if (a < 11'd1536) begin exp_wren = 1; ref_mem[a] = wd; end
            end else begin
               exp_rd = (a < 11'd1536) ? ref_mem[a] : 8'h00;
            end
         end
         sample();
         exp_v = (dq.size() > 0) && (dq[0].due == c);
         checks++;
         if (disp_valid !== exp_v) begin
            errors++; $display("FAIL mix_disp_valid[%0d]: got %b expected %b", c, disp_valid, exp_v);
         end else if (exp_v) begin
            checks++;
            if (disp_data !== dq[0].d) begin
               errors++; $display("FAIL mix_disp_data[%0d]: got %h expected %h", c, disp_data, dq[0].d);
            end
         end
         if (exp_v) void'(dq.pop_front());
         checks++;
         if (ram_wren !== exp_wren) begin
            errors++; $display("FAIL mix_wren[%0d]: got %b expected %b", c, ram_wren, exp_wren);
         end else if (exp_wren && (ram_addr !== a || ram_wdata !== wd)) begin
            errors++; $display("FAIL mix_wr_port[%0d]: addr=%0d data=%h expected %0d/%h", c, ram_addr, ram_wdata, a, wd);
         end
         exp_ack = act && gnt && (due == c);
         checks++;
         if (cpu_ack !== exp_ack) begin
            errors++; $display("FAIL mix_ack[%0d]: got %b expected %b", c, cpu_ack, exp_ack);
         end else if (exp_ack && !we && cpu_rdata !== exp_rd) begin
            errors++; $display("FAIL mix_rdata[%0d]: got %h expected %h", c, cpu_rdata, exp_rd);
         end
         if (exp_ack) act = 0;
         tick();
      end
      set_idle();
      checks++;
      if (act || dq.size() != 0) begin
         errors++; $display("FAIL mix_drain: cpu_pending=%b disp_pending=%0d expected 0/0", act, dq.size());
      end
   endtask

   task automatic test_clear_with_display();
      int busy_cnt = 0, nwr = 0, bad_wren = 0, bad_ack = 0, bad_seq = 0, bad_fill = 0;
      bit done = 0;
      logic [7:0] rd = '0;
      clr_start = 1; clr_char = 8'h20;
      sample();
      tick();
      clr_start = 0; clr_char = 8'hFF;
      for (int k = 0; k < 8000 && !done; k++) begin
         disp_req = (k % 2 == 0); disp_addr = '0;
         cpu_req = (k >= 3); cpu_we = 0; cpu_addr = 11'd100;
         sample();
         if (clr_busy === 1'b1) begin
            busy_cnt++;
            if (ram_wren !== !disp_req) bad_wren++;
            if (cpu_ack !== 1'b0) bad_ack++;
            if (!disp_req) begin
               if (ram_addr !== 11'(nwr) || ram_wdata !== 8'h20) bad_seq++;
               nwr++;
            end
         end else if (cpu_ack === 1'b1) begin
            done = 1; rd = cpu_rdata;
         end
         tick();
      end
      set_idle();
      for (int i = 0; i < NW; i++) begin
         if (ram[i] !== 8'h20) bad_fill++;
         ref_mem[i] = 8'h20;
      end
      checks++;
      if (!done) begin errors++; $display("FAIL clr_cpu_ack: got none expected ack after clear"); end
      checks++;
      if (busy_cnt < 3071 || busy_cnt > 3073) begin
         errors++; $display("FAIL clr_busy_len: got %0d expected 3072+/-1", busy_cnt);
      end
      checks++;
      if (bad_wren != 0 || bad_ack != 0) begin
         errors++; $display("FAIL clr_wren_ack: bad_wren=%0d bad_ack=%0d expected 0/0", bad_wren, bad_ack);
      end
      checks++;
      if (nwr != NW || bad_seq != 0) begin
         errors++; $display("FAIL clr_sequence: writes=%0d bad=%0d expected 1536/0", nwr, bad_seq);
      end
      checks++;
      if (bad_fill != 0) begin errors++; $display("FAIL clr_fill: bad_words=%0d expected 0", bad_fill); end
      checks++;
      if (rd !== 8'h20) begin errors++; $display("FAIL clr_cpu_rdata: got %h expected 20", rd); end
   endtask

   task automatic test_clear_vs_cpu();
      int busy_cnt = 0, ack_k = -1, bad = 0, bad_fill = 0;
      clr_start = 1; clr_char = 8'h5A;
      cpu_req = 1; cpu_we = 1; cpu_addr = 11'd1600; cpu_wdata = 8'h77;
      sample();
      checks++;
      if (ram_wren !== 1'b0 || ram_addr === 11'd1600) begin
         errors++; $display("FAIL clrcpu_start_grant: wren=%b addr=%0d expected no CPU grant", ram_wren, ram_addr);
      end
      tick();
      clr_start = 0;
      for (int k = 0; k < 2000 && ack_k < 0; k++) begin
         sample();
         if (clr_busy === 1'b1) begin
            busy_cnt++;
            if (cpu_ack !== 1'b0) bad++;
         end else begin
            if (ram_wren !== 1'b0) bad++;
            if (cpu_ack === 1'b1) ack_k = k;
         end
         tick();
      end
      set_idle();
      for (int i = 0; i < NW; i++) begin
         if (ram[i] !== 8'h5A) bad_fill++;
         ref_mem[i] = 8'h5A;
      end
      checks++;
      if (ack_k != 1537) begin errors++; $display("FAIL clrcpu_ack_cycle: got %0d expected 1537", ack_k); end
      checks++;
      if (busy_cnt != NW) begin errors++; $display("FAIL clrcpu_busy_len: got %0d expected 1536", busy_cnt); end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL clrcpu_oor_write: bad_cycles=%0d expected 0", bad); end
      checks++;
      if (bad_fill != 0) begin errors++; $display("FAIL clrcpu_fill: bad_words=%0d expected 0", bad_fill); end
   endtask

   task automatic test_reset_mid_clear();
      int bad = 0, bad_lo = 0, bad_hi = 0, ack_k = -1;
      logic [7:0] rd = '0;
      clr_start = 1; clr_char = 8'h33;
      sample();
      tick();
      clr_start = 0;
      for (int k = 0; k < 700; k++) begin
         sample();
         if (clr_busy !== 1'b1 || ram_wren !== 1'b1 || ram_addr !== 11'(k)) bad++;
         tick();
      end
      RESET = 1;
      sample();
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rstclr_progress: bad_cycles=%0d expected 0", bad); end
      checks++;
      if (ram_wren !== 1'b0) begin errors++; $display("FAIL rstclr_wren: got %b expected 0", ram_wren); end
      tick();
      RESET = 0;
      sample();
      checks++;
      if (clr_busy !== 1'b0 || cpu_ack !== 1'b0) begin
         errors++; $display("FAIL rstclr_busy: busy=%b ack=%b expected 0/0", clr_busy, cpu_ack);
      end
      for (int i = 0; i < NW; i++) begin
         if (i < 700 && ram[i] !== 8'h33) bad_lo++;
         if (i >= 700 && ram[i] !== 8'h5A) bad_hi++;
      end
      for (int i = 0; i < 700; i++) ref_mem[i] = 8'h33;
      checks++;
      if (bad_lo != 0 || bad_hi != 0) begin
         errors++; $display("FAIL rstclr_contents: bad_low=%0d bad_high=%0d expected 0/0", bad_lo, bad_hi);
      end
      tick();
      cpu_req = 1; cpu_we = 0; cpu_addr = 11'd800;
      for (int k = 0; k < 10 && ack_k < 0; k++) begin
         sample();
         if (cpu_ack === 1'b1) begin ack_k = k; rd = cpu_rdata; end
         tick();
      end
      cpu_req = 0;
      checks++;
      if (ack_k != 2 || rd !== ref_mem[800]) begin
         errors++; $display("FAIL rstclr_new_read: ack_cycle=%0d rdata=%h expected 2/%h", ack_k, rd, ref_mem[800]);
      end
   endtask

   task automatic test_reset_mid_read();
      int acks = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 11'd900;
      sample();
      checks++;
      if (ram_addr !== 11'd900) begin errors++; $display("FAIL rstrd_grant: addr=%0d expected 900", ram_addr); end
      tick();
      RESET = 1; cpu_req = 0;
      tick();
      RESET = 0;
      for (int k = 0; k < 4; k++) begin
         sample();
         if (cpu_ack !== 1'b0) acks++;
         tick();
      end
      checks++;
      if (acks != 0 || cpu_rdata !== 8'h00) begin
         errors++; $display("FAIL rstrd_no_ack: acks=%0d rdata=%h expected 0/00", acks, cpu_rdata);
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      RESET = 1;
      set_idle();
      test_reset();
      test_display_only();
      test_cpu_write_read();
      test_display_priority();
      test_random_mix();
      test_clear_with_display();
      test_clear_vs_cpu();
      test_reset_mid_clear();
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
